// File: rtl/ones_pkg.sv
// Shared types, defaults and helpers for the ones-pattern generator.
package ones_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefCw    = 4;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // Clamp a requested ones count to the word width.
  function automatic int unsigned sat_count(input int unsigned count, input int unsigned width);
    return (count > width) ? width : count;
  endfunction

endpackage

// File: rtl/ones_thermo_enc.sv
// Combinational thermometer encoder: n -> word with bits [n-1:0] set.
module ones_thermo_enc
  import ones_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CW    = DefCw
) (
  input  logic [CW-1:0]    n,
  output logic [WIDTH-1:0] word
);

  logic [WIDTH-1:0] all_ones;

  // Shifting an all-ones word left by n and inverting leaves n ones at the
  // bottom; n == WIDTH shifts everything out and yields all ones, so there is
  // no overflow case. n is already clamped by the caller.
  always_comb begin
    all_ones = '1;
    word     = ~(all_ones << n);
  end

endmodule

// File: rtl/ones_pattern_gen.sv
// Ones-pattern generator: accepts a ones count, emits the thermometer word in
// parallel and shifts it out LSB first under a valid/ready handshake.
module ones_pattern_gen
  import ones_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CW    = DefCw
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    count_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy,
  output logic             sat_err
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(WIDTH - 1);

  state_e           state;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    n_sat;
  logic             sat;
  logic [WIDTH-1:0] enc_word;
  logic             accept;
  logic             xfer;

  // Clamp the incoming count and flag saturation.
  always_comb begin
    sat   = (32'(count_in) > WIDTH);
    n_sat = CW'(sat_count(32'(count_in), WIDTH));
  end

  ones_thermo_enc #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_enc (
    .n    (n_sat),
    .word (enc_word)
  );

  assign accept = in_valid && in_ready;
  assign xfer   = ser_valid && ser_ready;

  // FSM, bit index and registered word/pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      idx        <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      sat_err    <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      sat_err    <= 1'b0;
      unique case (state)
        StIdle: begin
          if (accept) begin
            word_out   <= enc_word;
            word_valid <= 1'b1;
            sat_err    <= sat;
            idx        <= '0;
            state      <= StShift;
          end
        end
        StShift: begin
          // Stalls hold idx, so ser_out is held and no bit is lost or repeated.
          if (xfer) begin
            if (idx == LastIdx) begin
              idx   <= '0;
              state <= StIdle;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Handshake and serial outputs decode straight from registered state.
  always_comb begin
    in_ready  = (state == StIdle);
    busy      = (state != StIdle);
    ser_valid = (state == StShift);
    ser_out   = ser_valid && word_out[idx];
    ser_last  = ser_valid && (idx == LastIdx);
  end

endmodule
